shared_reg_arbiter: RTL

//   Round-robin arbiter that shares one 32-bit enable-load storage register between
//   NUM_REQ requesters. It picks one requester per transaction, drives the register's

---
 rtl/shared_reg_arbiter_pkg.sv | 23 ++
 rtl/shared_reg_arbiter_if.sv | 40 ++++
 rtl/shared_reg_arbiter_rr_picker.sv | 45 ++++
 rtl/shared_reg_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/shared_reg_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// shared_reg_arbiter_pkg
//   Shared types and constants for the round-robin shared-register arbiter.
//   - arb_state_e : FSM state encoding (2'b11 is illegal).
//   - DEFAULT_NUM_REQ / DEFAULT_WIDTH : default requester count and data width.
//   - idx_width() : width of a requester index, never less than 1 bit.
// ---------------------------------------------------------------------------
package shared_reg_arbiter_pkg;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_WIDTH   = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_WRITE = 2'b01,
    ARB_ACK   = 2'b10
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// ---------------------------------------------------------------------------
// shared_reg_arbiter_if
//   Bundle between the requesters (master) and the arbiter (slave).
//   req       : per-requester write request
//   reqData   : requester i data at [i*WIDTH +: WIDTH]
//   grant     : one-hot, high during WRITE for the winner
//   ack       : one-hot, single-cycle pulse in ACK for the winner
//   regEn     : load enable towards the shared storage register
//   regDataIn : data towards the shared storage register
//   regOwner  : index of the last requester written
//   busy      : high while a transaction is in WRITE or ACK
// ---------------------------------------------------------------------------
interface shared_reg_arbiter_if
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH
);
  localparam int IDX_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] reqData;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       ack;
  logic                     regEn;
  logic [WIDTH-1:0]         regDataIn;
  logic [IDX_W-1:0]         regOwner;
  logic                     busy;

  modport master (
    output req, reqData,
    input  grant, ack, regEn, regDataIn, regOwner, busy
  );

  modport slave (
    input  req, reqData,
    output grant, ack, regEn, regDataIn, regOwner, busy
  );

endinterface

// File: rtl/shared_reg_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin selector. Searches req_i upward from rr_ptr_i
//   with wrap-around and returns the first set bit.
//   req_i      : request vector
//   rr_ptr_i   : index where the search starts
//   pick_o     : one-hot of the selected requester (all zero if no request)
//   pick_idx_o : index of the selected requester (0 if no request)
// ---------------------------------------------------------------------------
module rr_picker
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [IDX_W-1:0]   pick_idx_o
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;
  logic             found;

  always_comb begin
    pick_o     = '0;
    pick_idx_o = '0;
    found      = 1'b0;
    pos        = 0;
    pos_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Explicit wrap keeps the search correct when NUM_REQ is not a power of 2.
      pos = int'(rr_ptr_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = pos[IDX_W-1:0];
      if (!found && req_i[pos_idx]) begin
        found          = 1'b1;
        pick_o[pos_idx] = 1'b1;
        pick_idx_o     = pos_idx;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// ---------------------------------------------------------------------------
// shared_reg_arbiter
//   Round-robin arbiter sharing one enable-load storage register between
//   NUM_REQ requesters. One transaction is IDLE -> WRITE -> ACK (3 cycles).
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : slave side of shared_reg_arbiter_if (req/reqData in; grant, ack,
//         regEn, regDataIn, regOwner, busy out)
// ---------------------------------------------------------------------------
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  shared_reg_arbiter_if.slave   bus
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_e         state_q;
  logic [IDX_W-1:0]   winner_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   rr_ptr_d;
  logic [IDX_W-1:0]   reg_owner_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               reg_en_q;
  logic               busy_q;
  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic [WIDTH-1:0]   reg_data_d;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i      (bus.req),
    .rr_ptr_i   (rr_ptr_q),
    .pick_o     (pick),
    .pick_idx_o (pick_idx)
  );

  // Next search start is the requester after the winner, wrapping explicitly.
  always_comb begin
    rr_ptr_d = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      winner_q    <= '0;
      rr_ptr_q    <= '0;
      reg_owner_q <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      reg_en_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|bus.req) begin
            winner_q <= pick_idx;
            grant_q  <= pick;
            reg_en_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ARB_WRITE;
          end
        end
        ARB_WRITE: begin
          // Write is committed regardless of req[winner] in this cycle.
          grant_q  <= '0;
          reg_en_q <= 1'b0;
          ack_q    <= grant_q;
          state_q  <= ARB_ACK;
        end
        ARB_ACK: begin
          ack_q       <= '0;
          busy_q      <= 1'b0;
          reg_owner_q <= winner_q;
          rr_ptr_q    <= rr_ptr_d;
          state_q     <= ARB_IDLE;
        end
        default: begin
          grant_q  <= '0;
          ack_q    <= '0;
          reg_en_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= ARB_IDLE;
        end
      endcase
    end
  end

  // Data mux is forced to zero outside WRITE so the register input is quiet.
  always_comb begin
    reg_data_d = '0;
    if (reg_en_q) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (winner_q == IDX_W'(i)) reg_data_d = bus.reqData[i*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.grant     = grant_q;
  assign bus.ack       = ack_q;
  assign bus.regEn     = reg_en_q;
  assign bus.regDataIn = reg_data_d;
  assign bus.regOwner  = reg_owner_q;
  assign bus.busy      = busy_q;

endmodule
